// File: rtl/periph_pkg.sv
// ---------------------------------------------------------------------------
// periph_pkg
// Shared constants for the memory-mapped timer peripheral.
//   - Register byte offsets inside the 32-byte peripheral window.
//   - Bit positions of the EN / IE / IF flags inside TCON.
//   - Terminal count value of the TL counter.
// ---------------------------------------------------------------------------
package periph_pkg;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  // Byte offset of a word register. The two byte-lane bits are dropped
  // because the window only supports whole-word accesses.
  function automatic logic [4:0] word_offset(input logic [2:0] reg_idx);
    return {reg_idx, 2'b00};
  endfunction

endpackage

// File: rtl/periph_timer.sv
// ---------------------------------------------------------------------------
// periph_timer
// Reloadable 32-bit up-counter with an overflow interrupt flag.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   wr_en    in   bus store that hits the peripheral window
//   wr_off   in   word-aligned byte offset of the store
//   wdata    in   store data
//   th       out  reload register TH
//   tl       out  counter register TL
//   tcon     out  {IF, IE, EN}
//   irq      out  interrupt request (IF & IE)
// ---------------------------------------------------------------------------
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_off,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q;
  logic [31:0] tl_q;
  logic        en_q;
  logic        ie_q;
  logic        if_q;

  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        overflow;
  logic        set_if;

  // Decode which timer register a store targets and detect the reload
  // cycle. The flag is raised from the IE value held before any store in
  // the same cycle.
  always_comb begin
    wr_th    = wr_en && (wr_off == OFF_TH);
    wr_tl    = wr_en && (wr_off == OFF_TL);
    wr_tcon  = wr_en && (wr_off == OFF_TCON);
    overflow = en_q && (tl_q == TL_MAX);
    set_if   = overflow && ie_q;
  end

  // Register update. A CPU store to TL overrides counting, the reload
  // always takes the TH value from before a same-cycle TH store, and an
  // overflow setting IF beats a software clear so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q <= '0;
      tl_q <= '0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      if_q <= 1'b0;
    end else begin
      if (wr_th) begin
        th_q <= wdata;
      end

      if (wr_tl) begin
        tl_q <= wdata;
      end else if (overflow) begin
        tl_q <= th_q;
      end else if (en_q) begin
        tl_q <= tl_q + 32'd1;
      end

      if (wr_tcon) begin
        en_q <= wdata[TCON_EN];
        ie_q <= wdata[TCON_IE];
        if_q <= wdata[TCON_IF] | set_if;
      end else if (set_if) begin
        if_q <= 1'b1;
      end
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = {if_q, ie_q, en_q};
  assign irq  = if_q & ie_q;

endmodule

// File: rtl/mmio_timer_periph.sv
// ---------------------------------------------------------------------------
// mmio_timer_periph
// MEM-stage peripheral responder: decodes a 32-byte window at BASE_ADDR and
// exposes a reloadable timer, LED and 7-segment latches and (optionally) a
// free-running systick counter.
//
// Optional feature macro: PERIPH_SYSTICK_EN
//   defined   -> 32-bit SYSTICK counter readable at offset 0x14
//   undefined -> no counter; offset 0x14 reads zero
//
// Parameters:
//   BASE_ADDR  window base, must be 32-byte aligned
//   LED_WIDTH  width of the LED latch (1..32)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   MemRead     in   load strobe
//   MemWrite    in   store strobe
//   Address     in   byte address
//   Write_data  in   store data
//   Read_data   out  load data (combinational, zero when not selected)
//   hit         out  Address lies inside the window
//   led         out  LED latch
//   digi        out  7-segment latch, [11:8] anodes, [7:0] segments
//   irq         out  timer interrupt request
// ---------------------------------------------------------------------------
module mmio_timer_periph
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  output logic [31:0]          Read_data,
  output logic                 hit,
  output logic [LED_WIDTH-1:0] led,
  output logic [11:0]          digi,
  output logic                 irq
);

  logic [4:0]           reg_off;
  logic                 wr_en;
  logic [LED_WIDTH-1:0] led_q;
  logic [11:0]          digi_q;
  logic [31:0]          systick_val;
  logic [31:0]          led_ext;
  logic [31:0]          timer_th;
  logic [31:0]          timer_tl;
  logic [2:0]           timer_tcon;
  logic                 unused_addr_lsbs;

  // The byte-lane bits carry no meaning for word-only accesses.
  assign unused_addr_lsbs = ^Address[1:0];

  assign hit     = (Address[31:5] == BASE_ADDR[31:5]);
  assign reg_off = word_offset(Address[4:2]);
  assign wr_en   = MemWrite && hit;

  periph_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_off (reg_off),
    .wdata  (Write_data),
    .th     (timer_th),
    .tl     (timer_tl),
    .tcon   (timer_tcon),
    .irq    (irq)
  );

  // LED and 7-segment output latches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else if (wr_en) begin
      if (reg_off == OFF_LED) begin
        led_q <= Write_data[LED_WIDTH-1:0];
      end
      if (reg_off == OFF_DIGI) begin
        digi_q <= Write_data[11:0];
      end
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q;

  // Free-running cycle counter; stores to its offset are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 32'd1;
    end
  end

  assign systick_val = systick_q;
`else
  assign systick_val = '0;
`endif

  // Zero-extend the LED latch so any LED_WIDTH up to 32 fits the bus.
  always_comb begin
    led_ext                = '0;
    led_ext[LED_WIDTH-1:0] = led_q;
  end

  // Load mux. Reads return the value held before a same-cycle store,
  // and anything not selected or unmapped reads as zero.
  always_comb begin
    Read_data = '0;
    if (MemRead && hit) begin
      case (reg_off)
        OFF_TH:      Read_data = timer_th;
        OFF_TL:      Read_data = timer_tl;
        OFF_TCON:    Read_data = {29'd0, timer_tcon};
        OFF_LED:     Read_data = led_ext;
        OFF_DIGI:    Read_data = {20'd0, digi_q};
        OFF_SYSTICK: Read_data = systick_val;
        default:     Read_data = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// ---------------------------------------------------------------------------
// tb_mmio_timer_periph
// Directed self-checking bench for mmio_timer_periph. Inputs change just
// after the falling clock edge; registered results are observed one falling
// edge after the rising edge that commits them.
// ---------------------------------------------------------------------------
module tb_mmio_timer_periph;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_DIGI    = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
  localparam logic [31:0] A_UNMAP   = 32'h4000_0018;
  localparam logic [31:0] A_OUTSIDE = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        hit;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int total_checks = 0;
  int pass_checks  = 0;

  mmio_timer_periph #(
    .BASE_ADDR (32'h4000_0000),
    .LED_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .hit        (hit),
    .led        (led),
    .digi       (digi),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    MemRead = 1'b1;
    Address = addr;
    #1;
    data    = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addr;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    reset      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_checks++;
    if ({led, digi, irq} !== 21'd0) begin
      $display("[TB] FAIL reset_outputs: got led=%h digi=%h irq=%b expected 0", led, digi, irq);
    end else pass_checks++;
    for (int i = 0; i < 6; i++) begin
      addr = A_TH + 32'(i * 4);
      bus_read(addr, rd);
      total_checks++;
      if (rd !== 32'h0) begin
        $display("[TB] FAIL reset_read_%0h: got %h expected 00000000", addr, rd);
      end else pass_checks++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_led_digi();
    logic [31:0] rd;
    bus_write(A_LED, 32'h0000_00A5);
    total_checks++;
    if (led !== 8'hA5) begin
      $display("[TB] FAIL led_latch: got %h expected a5", led);
    end else pass_checks++;
    bus_write(A_DIGI, 32'h0000_03FF);
    total_checks++;
    if (digi !== 12'h3FF) begin
      $display("[TB] FAIL digi_latch: got %h expected 3ff", digi);
    end else pass_checks++;
    bus_read(A_LED, rd);
    total_checks++;
    if (rd !== 32'h0000_00A5) begin
      $display("[TB] FAIL led_read: got %h expected 000000a5", rd);
    end else pass_checks++;
    bus_read(A_DIGI, rd);
    total_checks++;
    if (rd !== 32'h0000_03FF) begin
      $display("[TB] FAIL digi_read: got %h expected 000003ff", rd);
    end else pass_checks++;
  endtask

  task automatic test_timer_reload();
    logic [31:0] rd;
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFFE) begin
      $display("[TB] FAIL tl_start: got %h expected fffffffe", rd);
    end else pass_checks++;
    @(negedge clk);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFFF || irq !== 1'b0) begin
      $display("[TB] FAIL tl_plus1: got tl=%h irq=%b expected tl=ffffffff irq=0", rd, irq);
    end else pass_checks++;
    @(negedge clk);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFF0) begin
      $display("[TB] FAIL tl_reload: got %h expected fffffff0", rd);
    end else pass_checks++;
    bus_read(A_TCON, rd);
    total_checks++;
    if (rd !== 32'h7 || irq !== 1'b1) begin
      $display("[TB] FAIL if_on_reload: got tcon=%h irq=%b expected tcon=7 irq=1", rd, irq);
    end else pass_checks++;
  endtask

  task automatic test_if_race();
    logic [31:0] rd;
    bus_write(A_TL, 32'hFFFF_FFFE);
    @(negedge clk);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL race_setup: got %h expected ffffffff", rd);
    end else pass_checks++;
    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, rd);
    total_checks++;
    if (rd !== 32'h7 || irq !== 1'b1) begin
      $display("[TB] FAIL if_set_wins: got tcon=%h irq=%b expected tcon=7 irq=1", rd, irq);
    end else pass_checks++;
    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, rd);
    total_checks++;
    if (rd !== 32'h3 || irq !== 1'b0) begin
      $display("[TB] FAIL if_clear: got tcon=%h irq=%b expected tcon=3 irq=0", rd, irq);
    end else pass_checks++;
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFF1) begin
      $display("[TB] FAIL tl_after_clear: got %h expected fffffff1", rd);
    end else pass_checks++;
  endtask

  task automatic test_tl_th_priority();
    logic [31:0] rd;
    bus_write(A_TL, 32'h0000_0100);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'h0000_0100) begin
      $display("[TB] FAIL tl_write_wins: got %h expected 00000100", rd);
    end else pass_checks++;
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h0000_1234);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFF0) begin
      $display("[TB] FAIL reload_old_th: got %h expected fffffff0", rd);
    end else pass_checks++;
    bus_read(A_TH, rd);
    total_checks++;
    if (rd !== 32'h0000_1234) begin
      $display("[TB] FAIL th_written: got %h expected 00001234", rd);
    end else pass_checks++;
  endtask

  task automatic test_disable_hold();
    logic [31:0] rd;
    bus_write(A_TCON, 32'h0);
    repeat (3) @(negedge clk);
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'hFFFF_FFF1 || irq !== 1'b0) begin
      $display("[TB] FAIL tl_hold: got tl=%h irq=%b expected tl=fffffff1 irq=0", rd, irq);
    end else pass_checks++;
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    bus_read(A_UNMAP, rd);
    total_checks++;
    if (rd !== 32'h0 || hit !== 1'b1) begin
      $display("[TB] FAIL unmapped_read: got data=%h hit=%b expected data=0 hit=1", rd, hit);
    end else pass_checks++;
    bus_read(A_OUTSIDE, rd);
    total_checks++;
    if (rd !== 32'h0 || hit !== 1'b0) begin
      $display("[TB] FAIL outside_read: got data=%h hit=%b expected data=0 hit=0", rd, hit);
    end else pass_checks++;
    Address = A_LED;
    #1;
    total_checks++;
    if (Read_data !== 32'h0) begin
      $display("[TB] FAIL no_strobe_read: got %h expected 00000000", Read_data);
    end else pass_checks++;
    bus_write(A_OUTSIDE + 32'hC, 32'h0000_0011);
    total_checks++;
    if (led !== 8'hA5) begin
      $display("[TB] FAIL outside_write: got led=%h expected a5", led);
    end else pass_checks++;
  endtask

  task automatic test_back_to_back();
    Address    = A_LED;
    Write_data = 32'h0000_005A;
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    #1;
    total_checks++;
    if (Read_data !== 32'h0000_00A5) begin
      $display("[TB] FAIL rw_old_value: got %h expected 000000a5", Read_data);
    end else pass_checks++;
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    total_checks++;
    if (led !== 8'h5A) begin
      $display("[TB] FAIL rw_commit: got %h expected 5a", led);
    end else pass_checks++;
  endtask

  task automatic test_systick();
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] exp_diff;
    logic [31:0] exp_after_wr;
    bus_read(A_SYSTICK, v0);
    repeat (10) @(negedge clk);
    bus_read(A_SYSTICK, v1);
`ifdef PERIPH_SYSTICK_EN
    exp_diff = 32'd10;
    total_checks++;
    if (v0 === 32'h0) begin
      $display("[TB] FAIL systick_running: got %h expected nonzero", v0);
    end else pass_checks++;
`else
    exp_diff = 32'd0;
    total_checks++;
    if (v0 !== 32'h0) begin
      $display("[TB] FAIL systick_absent: got %h expected 00000000", v0);
    end else pass_checks++;
`endif
    total_checks++;
    if (v1 - v0 !== exp_diff) begin
      $display("[TB] FAIL systick_delta: got %h expected %h", v1 - v0, exp_diff);
    end else pass_checks++;
    bus_read(A_SYSTICK, v0);
    bus_write(A_SYSTICK, 32'hDEAD_BEEF);
    bus_read(A_SYSTICK, v1);
`ifdef PERIPH_SYSTICK_EN
    exp_after_wr = v0 + 32'd1;
`else
    exp_after_wr = 32'h0;
`endif
    total_checks++;
    if (v1 !== exp_after_wr) begin
      $display("[TB] FAIL systick_write_ignored: got %h expected %h", v1, exp_after_wr);
    end else pass_checks++;
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] rd;
    bus_write(A_TH, 32'h0000_0007);
    bus_write(A_TL, 32'h0000_0005);
    bus_write(A_TCON, 32'h7);
    total_checks++;
    if (irq !== 1'b1) begin
      $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq);
    end else pass_checks++;
    reset      = 1'b0;
    Address    = A_LED;
    Write_data = 32'h0000_00FF;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    total_checks++;
    if ({led, digi, irq} !== 21'd0) begin
      $display("[TB] FAIL mid_reset_outputs: got led=%h digi=%h irq=%b expected 0", led, digi, irq);
    end else pass_checks++;
    bus_read(A_TL, rd);
    total_checks++;
    if (rd !== 32'h0) begin
      $display("[TB] FAIL mid_reset_tl: got %h expected 00000000", rd);
    end else pass_checks++;
    bus_read(A_TCON, rd);
    total_checks++;
    if (rd !== 32'h0) begin
      $display("[TB] FAIL mid_reset_tcon: got %h expected 00000000", rd);
    end else pass_checks++;
    bus_read(A_TH, rd);
    total_checks++;
    if (rd !== 32'h0) begin
      $display("[TB] FAIL mid_reset_th: got %h expected 00000000", rd);
    end else pass_checks++;
  endtask

  initial begin
    test_reset();
    test_led_digi();
    test_timer_reload();
    test_if_race();
    test_tl_th_priority();
    test_disable_hold();
    test_decode();
    test_back_to_back();
    test_systick();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
